// File: rtl/axis_rr_packet_arbiter.sv
// Packet-locked round-robin arbiter sharing one AXI-Stream egress among NUM_PORTS ingress streams.
// Optional per-port packet counters are built when AXIS_ARB_PKT_COUNT_EN is defined.
module axis_rr_packet_arbiter #(
   parameter int unsigned NUM_PORTS       = 4,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned DATA_BYTE_WIDTH = DATA_WIDTH / 8,
   parameter int unsigned IDX_WIDTH       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NUM_PORTS-1:0]                 s_valid,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]      s_data,
   input  logic [NUM_PORTS*DATA_BYTE_WIDTH-1:0] s_keep,
   input  logic [NUM_PORTS-1:0]                 s_last,
   output logic [NUM_PORTS-1:0]                 s_ready,
   output logic                                 m_valid,
   output logic [DATA_WIDTH-1:0]                m_data,
   output logic [DATA_BYTE_WIDTH-1:0]           m_keep,
   output logic                                 m_last,
   input  logic                                 m_ready,
`ifdef AXIS_ARB_PKT_COUNT_EN
   output logic [NUM_PORTS*16-1:0]              pkt_count,
   input  logic                                 pkt_count_clr,
`endif
   output logic                                 grant_valid,
   output logic [IDX_WIDTH-1:0]                 grant_idx
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t               state;
   logic [IDX_WIDTH-1:0] rr_ptr;
   logic [IDX_WIDTH-1:0] pick;
   logic                 any_req;
   logic                 last_hs;
   int                   p;

   // Round-robin pick: first requester after rr_ptr, wrapping modulo NUM_PORTS.
   // Scanning from the far end lets the nearest requester win by being assigned last.
   always_comb begin
      any_req = |s_valid;
      pick    = '0;
      p       = 0;
      for (int k = int'(NUM_PORTS); k >= 1; k--) begin
         p = int'(rr_ptr) + k;
         if (p >= int'(NUM_PORTS)) begin
            p = p - int'(NUM_PORTS);
         end
         if (s_valid[IDX_WIDTH'(p)]) begin
            pick = IDX_WIDTH'(p);
         end
      end
   end

   // Egress mux: combinational pass-through of the granted port while in GRANT.
   always_comb begin
      m_valid = 1'b0;
      m_data  = '0;
      m_keep  = '0;
      m_last  = 1'b0;
      s_ready = '0;
      if (state == GRANT) begin
         for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (grant_idx == IDX_WIDTH'(i)) begin
               m_valid    = s_valid[i];
               m_data     = s_data[i*DATA_WIDTH +: DATA_WIDTH];
               m_keep     = s_keep[i*DATA_BYTE_WIDTH +: DATA_BYTE_WIDTH];
               m_last     = s_last[i];
               s_ready[i] = m_ready;
            end
         end
      end
   end

   assign last_hs = (state == GRANT) && m_valid && m_ready && m_last;

   // Grant FSM: the owner keeps the egress until its tlast beat handshakes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         grant_idx   <= '0;
         grant_valid <= 1'b0;
         rr_ptr      <= IDX_WIDTH'(NUM_PORTS - 1);
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  state       <= GRANT;
                  grant_idx   <= pick;
                  grant_valid <= 1'b1;
               end
            end
            GRANT: begin
               if (last_hs) begin
                  state       <= IDLE;
                  rr_ptr      <= grant_idx;
                  grant_idx   <= '0;
                  grant_valid <= 1'b0;
               end
            end
            default: begin
               state       <= IDLE;
               grant_idx   <= '0;
               grant_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef AXIS_ARB_PKT_COUNT_EN
   localparam int unsigned CNT_WIDTH = 16;

   // Saturating per-port completed-packet counters; clear beats increment.
   for (genvar i = 0; i < int'(NUM_PORTS); i++) begin : g_cnt
      logic [CNT_WIDTH-1:0] cnt;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt <= '0;
         end else if (pkt_count_clr) begin
            cnt <= '0;
         end else if (last_hs && (grant_idx == IDX_WIDTH'(i)) && (cnt != {CNT_WIDTH{1'b1}})) begin
            cnt <= cnt + CNT_WIDTH'(1);
         end
      end

      assign pkt_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt;
   end
`endif

endmodule
